// File: rtl/capp_pkg.sv
// Shared types, default geometry and opcode helpers for the CAPP sequencer.
package capp_pkg;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_NUM_WORDS  = 4096;
    localparam int DEF_BANK_WORDS = 256;

    typedef enum logic [2:0] {
        OP_SET_ALL    = 3'd0,
        OP_SEARCH     = 3'd1,
        OP_SEARCH_AND = 3'd2,
        OP_READ       = 3'd3,
        OP_WRITE      = 3'd4,
        OP_FIRST      = 3'd5
    } capp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } capp_state_t;

    function automatic int bank_idx_w(input int num_words, input int bank_words);
        int nb;
        nb = num_words / bank_words;
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    function automatic logic op_reads_array(input logic [2:0] op);
        return (op == OP_SEARCH) || (op == OP_SEARCH_AND) || (op == OP_READ);
    endfunction

    function automatic logic op_sweeps(input logic [2:0] op);
        return op_reads_array(op) || (op == OP_WRITE) || (op == OP_FIRST);
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return op > 3'd5;
    endfunction

endpackage

// File: rtl/capp_bank_match.sv
// Per-bank comparator: match vector for one bank of words plus the masked OR
// of the words selected by the tag slice.
module capp_bank_match
    import capp_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int BANK_WORDS = DEF_BANK_WORDS
) (
    input  logic [BANK_WORDS*WORD_W-1:0] words,
    input  logic [WORD_W-1:0]            data,
    input  logic [WORD_W-1:0]            mask,
    input  logic [BANK_WORDS-1:0]        sel,
    output logic [BANK_WORDS-1:0]        match,
    output logic [WORD_W-1:0]            sel_or
);

    always_comb begin
        match  = '0;
        sel_or = '0;
        for (int j = 0; j < BANK_WORDS; j++) begin
            match[j] = (((words[j*WORD_W +: WORD_W] ^ data) & mask) == '0);
            if (sel[j]) begin
                sel_or = sel_or | (words[j*WORD_W +: WORD_W] & mask);
            end
        end
    end

endmodule

// File: rtl/capp_controller.sv
// CAPP sequencer: accepts associative commands, sweeps the banked cell array
// one bank per cycle, owns the per-word tag register and returns one response.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_SWEEP | bank counter walks 0..NUM_BANKS-1, one array access per cycle
// ST_DRAIN | consume the last bank's read data (one cycle behind the issue)
// ST_RESP  | response held on rsp_* until rsp_ready
module capp_controller
    import capp_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int NUM_WORDS  = DEF_NUM_WORDS,
    parameter int BANK_WORDS = DEF_BANK_WORDS,
    localparam int NUM_BANKS  = NUM_WORDS / BANK_WORDS,
    localparam int BANK_IDX_W = bank_idx_w(NUM_WORDS, BANK_WORDS)
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [WORD_W-1:0]             cmd_data,
    input  logic [WORD_W-1:0]             cmd_mask,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WORD_W-1:0]             rsp_data,
    output logic                          rsp_hit,
    output logic                          rsp_err,
    output logic [BANK_IDX_W-1:0]         arr_bank,
    output logic                          arr_rd_en,
    input  logic [BANK_WORDS*WORD_W-1:0]  arr_rd_data,
    output logic                          arr_wr_en,
    output logic [WORD_W-1:0]             arr_wr_data,
    output logic [WORD_W-1:0]             arr_wr_mask,
    output logic [BANK_WORDS-1:0]         arr_wr_sel
);

    capp_state_t               state_q, state_d;
    logic [2:0]                op_q, op_d, cur_op;
    logic [WORD_W-1:0]         data_q, data_d, mask_q, mask_d;
    logic [BANK_IDX_W-1:0]     bank_q, bank_d, proc_bank_q;
    logic                      proc_valid_q;
    logic [WORD_W-1:0]         acc_q, acc_d;
    logic                      found_q, found_d;
    logic [NUM_WORDS-1:0]      tag_q, tag_d;

    logic                      cmd_ready_q;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]         rsp_data_q, rsp_data_d;
    logic                      rsp_hit_q, rsp_hit_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rd_en_q, rd_en_d;
    logic                      wr_en_q, wr_en_d;
    logic [BANK_WORDS-1:0]     wr_sel_q, wr_sel_d;

    logic                      accept;
    logic                      last_bank;
    logic [BANK_WORDS-1:0]     proc_slice, sweep_slice;
    logic [BANK_WORDS-1:0]     match_v;
    logic [WORD_W-1:0]         sel_or;

    assign accept      = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    assign last_bank   = (bank_q == BANK_IDX_W'(NUM_BANKS - 1));
    assign cur_op      = (state_q == ST_IDLE) ? cmd_op : op_q;
    assign proc_slice  = tag_q[int'(proc_bank_q)*BANK_WORDS +: BANK_WORDS];
    assign sweep_slice = tag_q[int'(bank_q)*BANK_WORDS +: BANK_WORDS];

    capp_bank_match #(
        .WORD_W     (WORD_W),
        .BANK_WORDS (BANK_WORDS)
    ) u_match (
        .words  (arr_rd_data),
        .data   (data_q),
        .mask   (mask_q),
        .sel    (proc_slice),
        .match  (match_v),
        .sel_or (sel_or)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_sweeps(cmd_op) ? ST_SWEEP : ST_RESP;
                end
            end
            ST_SWEEP: begin
                if (last_bank) begin
                    state_d = op_reads_array(op_q) ? ST_DRAIN : ST_RESP;
                end
            end
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tag_d       = tag_q;
        acc_d       = acc_q;
        found_d     = found_q;
        bank_d      = bank_q;
        op_d        = op_q;
        data_d      = data_q;
        mask_d      = mask_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        wr_sel_d    = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_err_d   = rsp_err_q;

        // Read data lags the bank issue by one cycle; proc_bank_q tracks it.
        if (proc_valid_q) begin
            case (op_q)
                OP_SEARCH:     tag_d[int'(proc_bank_q)*BANK_WORDS +: BANK_WORDS] = match_v;
                OP_SEARCH_AND: tag_d[int'(proc_bank_q)*BANK_WORDS +: BANK_WORDS] = proc_slice & match_v;
                OP_READ:       acc_d = acc_q | sel_or;
                default:       ;
            endcase
        end

        if ((state_q == ST_SWEEP) && (op_q == OP_FIRST)) begin
            if (!found_q) begin
                tag_d[int'(bank_q)*BANK_WORDS +: BANK_WORDS] =
                    sweep_slice & (~sweep_slice + BANK_WORDS'(1));
                found_d = |sweep_slice;
            end else begin
                tag_d[int'(bank_q)*BANK_WORDS +: BANK_WORDS] = '0;
            end
        end

        if (accept) begin
            op_d    = cmd_op;
            data_d  = cmd_data;
            mask_d  = cmd_mask;
            bank_d  = '0;
            acc_d   = '0;
            found_d = 1'b0;
            case (cmd_op)
                OP_SET_ALL: tag_d = '1;
                OP_SEARCH, OP_SEARCH_AND, OP_READ: rd_en_d = 1'b1;
                OP_WRITE: begin
                    wr_en_d  = 1'b1;
                    wr_sel_d = tag_q[BANK_WORDS-1:0];
                end
                default: ;
            endcase
        end

        if ((state_q == ST_SWEEP) && !last_bank) begin
            bank_d  = bank_q + BANK_IDX_W'(1);
            rd_en_d = op_reads_array(op_q);
            if (op_q == OP_WRITE) begin
                wr_en_d  = 1'b1;
                wr_sel_d = tag_q[(int'(bank_q) + 1)*BANK_WORDS +: BANK_WORDS];
            end
        end

        // Hit is taken from the post-update tags on the RESP entry cycle.
        if ((state_q != ST_RESP) && (state_d == ST_RESP)) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = |tag_d;
            rsp_err_d   = op_illegal(cur_op);
            rsp_data_d  = (cur_op == OP_READ) ? acc_d : '0;
        end

        if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_hit_d   = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            op_q         <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            bank_q       <= '0;
            proc_bank_q  <= '0;
            proc_valid_q <= 1'b0;
            acc_q        <= '0;
            found_q      <= 1'b0;
            tag_q        <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
        end else begin
            op_q         <= op_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            bank_q       <= bank_d;
            proc_bank_q  <= bank_q;
            proc_valid_q <= rd_en_q;
            acc_q        <= acc_d;
            found_q      <= found_d;
            tag_q        <= tag_d;
            cmd_ready_q  <= (state_d == ST_IDLE);
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_err_q    <= rsp_err_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_err     = rsp_err_q;
    assign arr_bank    = bank_q;
    assign arr_rd_en   = rd_en_q;
    assign arr_wr_en   = wr_en_q;
    assign arr_wr_data = data_q;
    assign arr_wr_mask = mask_q;
    assign arr_wr_sel  = wr_sel_q;

endmodule

// File: tb/tb_capp_controller.sv
// Scoreboard bench for capp_controller on a 4-bank, 64-word array preloaded with word i = i.
module tb_capp_controller;

    localparam int WW = 32;
    localparam int NW = 64;
    localparam int BW = 16;
    localparam int NB = 4;

    localparam logic [2:0] C_SET_ALL = 3'd0;
    localparam logic [2:0] C_SEARCH  = 3'd1;
    localparam logic [2:0] C_SAND    = 3'd2;
    localparam logic [2:0] C_READ    = 3'd3;
    localparam logic [2:0] C_WRITE   = 3'd4;
    localparam logic [2:0] C_FIRST   = 3'd5;

    logic              CLK = 1'b0;
    logic              RESETN = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [WW-1:0]     cmd_data = '0;
    logic [WW-1:0]     cmd_mask = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [WW-1:0]     rsp_data;
    logic              rsp_hit;
    logic              rsp_err;
    logic [1:0]        arr_bank;
    logic              arr_rd_en;
    logic [BW*WW-1:0]  arr_rd_data;
    logic              arr_wr_en;
    logic [WW-1:0]     arr_wr_data;
    logic [WW-1:0]     arr_wr_mask;
    logic [BW-1:0]     arr_wr_sel;

    capp_controller #(
        .WORD_W     (WW),
        .NUM_WORDS  (NW),
        .BANK_WORDS (BW)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_hit     (rsp_hit),
        .rsp_err     (rsp_err),
        .arr_bank    (arr_bank),
        .arr_rd_en   (arr_rd_en),
        .arr_rd_data (arr_rd_data),
        .arr_wr_en   (arr_wr_en),
        .arr_wr_data (arr_wr_data),
        .arr_wr_mask (arr_wr_mask),
        .arr_wr_sel  (arr_wr_sel)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WW-1:0] data;
        logic          hit;
        logic          err;
        int            lat;
        int            acc;
        string         nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   last_acc = 0;
    bit   seen = 1'b0;
    bit   pend_done = 1'b0;
    logic [BW-1:0] wr_sel_log [NB] = '{default: 16'h5A5A};

    always @(posedge CLK) cyc <= cyc + 1;

    // Array model: registered read (data one cycle later), masked write on tagged words.
    logic [WW-1:0] mem [NW];
    bit            loaded = 1'b0;
    always @(posedge CLK) begin
        if (!loaded) begin
            for (int i = 0; i < NW; i++) mem[i] <= 32'(i);
            arr_rd_data <= '0;
            loaded      <= 1'b1;
        end else begin
            if (arr_rd_en) begin
                for (int j = 0; j < BW; j++)
                    arr_rd_data[j*WW +: WW] <= mem[int'(arr_bank)*BW + j];
            end
            if (arr_wr_en) begin
                for (int j = 0; j < BW; j++)
                    if (arr_wr_sel[j])
                        mem[int'(arr_bank)*BW + j] <= (mem[int'(arr_bank)*BW + j] & ~arr_wr_mask)
                                                     | (arr_wr_data & arr_wr_mask);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp_v);
    endtask

    always @(negedge CLK) begin
        if (arr_rd_en || arr_wr_en) en_cnt++;
        if (arr_wr_en) wr_sel_log[arr_bank] = arr_wr_sel;
    end

    // Monitor: pop one expectation on each new response.
    always @(negedge CLK) begin
        if (RESETN && rsp_valid && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_data"}, rsp_data, e.data);
                chk({e.nm, "_hit"}, 32'(rsp_hit), 32'(e.hit));
                chk({e.nm, "_err"}, 32'(rsp_err), 32'(e.err));
                chk({e.nm, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        if (rsp_valid && rsp_ready) seen = 1'b0;
    end

    // Call at posedge+#1. Returns just after the accept edge; cycle 0 is the accept cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] m,
                         input logic [31:0] ed, input logic eh, input logic ee,
                         input int elat, input string nm);
        exp_t e;
        int   n;
        n = 0;
        cmd_op = op; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!cmd_ready) begin
            n_chk++;
            $display("FAIL %s_accept: got cmd_ready=0 want 1 within 100 cycles", nm);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        last_acc  = cyc;
        e.data = ed; e.hit = eh; e.err = ee; e.lat = elat; e.acc = cyc - 1; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            $display("FAIL drain: got %0d pending responses want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no $finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, en0, hs;
        RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_arr_en", 32'({arr_rd_en, arr_wr_en}), 32'd0);
        @(posedge CLK); #1 RESETN = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        issue(C_READ,    32'h0, 32'hFFFFFFFF, 32'h0,  1'b0, 1'b0, 6, "read_empty");
        issue(C_SET_ALL, 32'h0, 32'h0,        32'h0,  1'b1, 1'b0, 1, "set_all");
        issue(C_SEARCH,  32'h25, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 6, "search_25");
        issue(C_READ,    32'h0, 32'hFFFFFFFF, 32'h25, 1'b1, 1'b0, 6, "read_25");
        issue(C_SEARCH,  32'h1, 32'h1,        32'h0,  1'b1, 1'b0, 6, "search_odd");
        issue(C_FIRST,   32'h0, 32'h0,        32'h0,  1'b1, 1'b0, 5, "first_odd");
        issue(C_READ,    32'h0, 32'hFFFFFFFF, 32'h1,  1'b1, 1'b0, 6, "read_first");
        issue(C_SEARCH,  32'h30, 32'h30,      32'h0,  1'b1, 1'b0, 6, "search_30");
        drain();
        en0 = en_cnt;
        issue(C_WRITE, 32'hA5A50000, 32'hFFFF0000, 32'h0, 1'b1, 1'b0, 5, "write_hi");
        drain();
        chk("write_en_cycles", 32'(en_cnt - en0), 32'd4);
        for (int b = 0; b < NB; b++)
            chk($sformatf("wr_sel_bank%0d", b), 32'(wr_sel_log[b]), (b == 3) ? 32'h0000FFFF : 32'h0);
        for (int i = 0; i < NW; i++)
            chk($sformatf("word%0d", i), mem[i], (i >= 48) ? (32'hA5A50000 | 32'(i)) : 32'(i));

        issue(C_SAND,   32'h0, 32'h30,        32'h0,  1'b0, 1'b0, 6, "sand_none");
        issue(C_READ,   32'h0, 32'hFFFFFFFF,  32'h0,  1'b0, 1'b0, 6, "read_none");
        issue(C_SEARCH, 32'h12345678, 32'h0,  32'h0,  1'b1, 1'b0, 6, "search_mask0");
        issue(C_READ,   32'h0, 32'hFFFFFFFF,  32'hA5A5003F, 1'b1, 1'b0, 6, "read_all");
        issue(C_SAND,   32'hA5A50000, 32'hFFFF0000, 32'h0, 1'b1, 1'b0, 6, "sand_hi");
        issue(C_FIRST,  32'h0, 32'h0,         32'h0,  1'b1, 1'b0, 5, "first_bank3");
        drain();

        rsp_ready = 1'b0;
        issue(C_READ, 32'h0, 32'hFFFFFFFF, 32'hA5A50030, 1'b1, 1'b0, 6, "read_hold");
        fork
            begin
                issue(3'd7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1, "illegal7");
                pend_done = 1'b1;
            end
        join_none
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, 32'hA5A50030);
            chk("hold_hit", 32'(rsp_hit), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge CLK); #1 rsp_ready = 1'b1;
        @(posedge CLK); #1 hs = cyc;
        n = 0;
        while (!pend_done && n < 20) begin
            @(posedge CLK); #2;
            n++;
        end
        chk("pending_accept_cyc", 32'(last_acc), 32'(hs + 1));
        drain();

        en0 = en_cnt;
        issue(3'd6, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1, "illegal6");
        drain();
        chk("illegal6_no_array", 32'(en_cnt - en0), 32'd0);

        cmd_op = C_SEARCH; cmd_data = 32'h0; cmd_mask = 32'h0; cmd_valid = 1'b1;
        @(posedge CLK); #1 cmd_valid = 1'b0;
        n = 0;
        while (!(arr_rd_en && arr_bank == 2'd2) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_mid_bank2_seen", 32'(arr_rd_en && arr_bank == 2'd2), 32'd1);
        RESETN = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid_rd_en", 32'(arr_rd_en), 32'd0);
        chk("rst_mid_wr_en", 32'(arr_wr_en), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        RESETN = 1'b1;
        @(posedge CLK); #1;
        chk("rst_mid_idle_ready", 32'(cmd_ready), 32'd1);
        issue(C_READ, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 6, "read_after_rst");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/capp_controller.md
# capp_controller

Sequencer for the content-addressable parallel processor (CAPP) cell array. It accepts associative commands from the host: search, tag and select, masked read, masked parallel write. It executes each command by sweeping the banked cell array one bank per cycle and owns the per-word tag register. Each command returns exactly one response. The block sits between the host command interface and the cell array storage.

## Interface
- WORD_W, 32, bits per cell word
- NUM_WORDS, 4096, cells in the array
- BANK_WORDS, 256, cells per bank; NUM_BANKS = NUM_WORDS/BANK_WORDS (integer power of two)

- CLK  in  1  single clock; all logic on rising edge
- RESETN  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  WORD_W  comparand or write data
- cmd_mask  in  WORD_W  bit mask; 1 = bit participates
- rsp_valid  out  1  response available
- rsp_ready  in  1  host consumes response
- rsp_data  out  WORD_W  READ result, else 0
- rsp_hit  out  1  any tag set after the command
- rsp_err  out  1  illegal opcode
- arr_bank  out  log2(NUM_BANKS)  bank index
- arr_rd_en  out  1  read the bank; data returns next cycle
- arr_rd_data  in  BANK_WORDS*WORD_W  bank contents, word j at [j*WORD_W +: WORD_W]
- arr_wr_en  out  1  masked write to the bank
- arr_wr_data  out  WORD_W  write data
- arr_wr_mask  out  WORD_W  bit write mask
- arr_wr_sel  out  BANK_WORDS  per-word write enable, equal to the bank's tag slice

## Operation
- Opcodes:
  - SET_ALL=0: all tags := 1.
  - SEARCH=1: tag[i] := match[i].
  - SEARCH_AND=2: tag[i] := tag[i] & match[i].
  - READ=3: rsp_data := OR over tagged words of (word & mask).
  - WRITE=4: tagged words get masked write.
  - FIRST=5: keep only the lowest-index set tag.
  - Codes 6–7: illegal.
- Match rule: match[i] = ((word[i] ^ cmd_data) & cmd_mask) == 0. A mask of 0 matches every word.
- FSM states: IDLE → SWEEP → DRAIN → RESP → IDLE.
  - SET_ALL and illegal opcodes go IDLE → RESP directly.
  - WRITE and FIRST go SWEEP → RESP; they need no read data.
- SWEEP: a bank counter runs 0..NUM_BANKS-1, one bank per cycle. SEARCH, SEARCH_AND and READ assert arr_rd_en; WRITE asserts arr_wr_en.
- DRAIN: consumes the last bank's read data, which arrives one cycle late.
- Read data for bank b is processed on the cycle after bank b is issued.
  - Tag updates for bank b happen on that cycle.
  - The READ accumulator ORs into a WORD_W register cleared at accept.
- FIRST: a found flag is cleared at accept. While scanning bank b:
  - If found is clear, keep only the lowest set bit of the slice and set found when any bit exists.
  - If found is set, clear the slice.
- rsp_hit = OR of all tags after the update; it is computed in the RESP entry cycle.
- Illegal opcode: no array access, tags unchanged. Response is rsp_err=1, rsp_data=0, rsp_hit reflects the current tags.
- cmd_ready = 1 only in IDLE. No new command is accepted while a response is pending.

## Timing
- Reset values: cmd_ready=0 during reset, 1 on the first cycle after. All other outputs are 0 and all tags are 0. State is IDLE, the bank counter is 0, the accumulator is 0.
- All outputs are registered.
- Accept happens at cycle 0; the bank b access is on cycle 1+b.
  - SEARCH, SEARCH_AND, READ: rsp_valid at cycle NUM_BANKS+2.
  - WRITE, FIRST: rsp_valid at cycle NUM_BANKS+1.
  - SET_ALL, illegal: rsp_valid at cycle 1.
- Response: rsp_valid, rsp_data, rsp_hit and rsp_err stay stable until rsp_ready. The cycle after consumption is IDLE with cmd_ready=1; back-to-back commands are spaced by one idle cycle.
- Reset mid-operation: on the next edge, state returns to IDLE, tags are cleared, and array enables drop. A partially completed WRITE is not rolled back.
- The bank counter does not wrap within a command; SWEEP exits after NUM_BANKS-1.

## Structure
- capp_pkg:
  - op enum (capp_op_t)
  - state enum
  - default WORD_W / NUM_WORDS / BANK_WORDS constants
  - a BANK_IDX_W function
- Sub-module capp_bank_match (combinational): takes one bank of words, cmd_data and cmd_mask. It returns the BANK_WORDS match vector plus the masked OR of the words under a tag-slice select. It is instantiated once.
- The tag register is a NUM_WORDS flop vector in capp_controller and is sliced by bank index.

## Test plan
Use the bench configuration NUM_WORDS=64, BANK_WORDS=16 (4 banks). The array model is preloaded with word i = i.
- Reset → cmd_ready=0 while RESETN=0, then 1. READ mask 0xFFFFFFFF → rsp at cycle 6: rsp_data=0, rsp_hit=0, rsp_err=0.
- SET_ALL, then SEARCH data=0x25 mask=0xFFFFFFFF → rsp_hit=1. READ mask 0xFFFFFFFF → rsp_data=0x25. Latencies are 1, 6 and 6 cycles.
- SEARCH data=0x1 mask=0x1 (odd words), then FIRST → rsp_hit=1. READ → rsp_data=0x1.
- SEARCH data=0x30 mask=0x30 (words 48–63), then WRITE data=0xA5A50000 mask=0xFFFF0000 → arr_wr_sel=0xFFFF only on bank 3. Array words 48–63 become 0xA5A500xx and words 0–47 are unchanged. rsp at cycle 5.
- Hold rsp_ready=0 for 10 cycles after a READ response → rsp fields stay stable, cmd_ready=0, and a pending cmd_valid is not accepted until the cycle after the rsp_ready handshake.
- Opcode 7 → rsp at cycle 1 with rsp_err=1 and no array enables. Pull RESETN low during bank 2 of a SEARCH → the next cycle is IDLE with all tags 0, then a READ returns rsp_hit=0.
